serial_diff_collector: RTL
==========================

Name: serial_diff_collector

Overview:
- Receive-side collector for the serial 4-bit-group subtractor/converter FSM. That FSM emits one result bit `D` and one borrow flag `B` per clock, LSB-first, in groups of GROUP_BITS bits.
- This block deserialises that stream into a parallel result word plus a per-group borrow vector.
- It hands the word to a parallel consumer over a valid/ready handshake through a one-entry output buffer.
- It sits directly downstream of the serial FSM, on the same clock.

Parameters:
- GROUP_BITS, 4, serial bits per group; the borrow is sampled on the last bit of each group.
- NUM_GROUPS, 2, groups per word; the word width is GROUP_BITS*NUM_GROUPS.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  reset, synchronous, active-low: sampled on the CLK rising edge; CLR=0 resets all state.
- start  input  1  frame start; bit 0 of a new word is present on d_in this cycle.
- bit_en  input  1  d_in/b_in carry a valid bit this cycle.
- d_in  input  1  serial result bit, LSB first.
- b_in  input  1  serial borrow flag.
- word_out  output  GROUP_BITS*NUM_GROUPS  assembled result word.
- borrow_out  output  NUM_GROUPS  borrow per group; bit g belongs to group g.
- out_valid  output  1  word_out/borrow_out hold a complete word.
- out_ready  input  1  consumer accepts the word.
- busy  output  1  a frame is in progress (COLLECT state).
- overrun  output  1  sticky: a completed word was dropped because the buffer was full.

Behaviour:
- Reset (CLR=0 at a rising edge):
  - state=IDLE, bit counter=0, shift register=0.
  - word_out=0, borrow_out=0, out_valid=0, busy=0, overrun=0.
  - Any partial frame is discarded.
  - Reset has priority over every other input in that cycle.
- A bit is accepted only in a cycle with bit_en=1.
- IDLE:
  - start=1 with bit_en=1: capture d_in as bit 0, set cnt=1, go to COLLECT.
  - start=1 with bit_en=0: ignored.
  - Bits arriving with start=0: ignored.
- COLLECT:
  - Each bit_en=1 cycle stores d_in into shift position cnt, then cnt increments.
  - bit_en=0 cycles hold state; gaps of any length are legal.
- Borrow capture:
  - On a bit with index mod GROUP_BITS == GROUP_BITS-1, b_in is stored into borrow bit index/GROUP_BITS.
  - b_in on all other bits is ignored.
- Frame complete:
  - The word completes on the bit with index GROUP_BITS*NUM_GROUPS-1.
  - That cycle: attempt transfer to the output buffer, return to IDLE, clear cnt.
- start=1 with bit_en=1 while in COLLECT:
  - Abort the partial frame without output.
  - Restart at bit 0 with the current d_in (cnt=1).
  - overrun is not affected.
- Output buffer:
  - Loaded at the clock edge ending the completing cycle; out_valid=1 from the next cycle.
  - Latency from the last serial bit to out_valid is 1 clock.
  - word_out/borrow_out are stable while out_valid=1.
  - A transfer occurs on any cycle with out_valid=1 and out_ready=1; out_valid falls next cycle unless a reload happens in the same cycle.
- Simultaneous completion and transfer:
  - Completion in the same cycle as an accepted transfer: the buffer reloads with the new word and out_valid stays 1.
- Buffer full:
  - Completion while out_valid=1 and out_ready=0: the new word is dropped, the buffer is unchanged, overrun=1.
  - overrun clears only on reset.
- busy=1 exactly while in COLLECT.
- Width rule: cnt is wide enough for 0..GROUP_BITS*NUM_GROUPS; it never wraps within a frame.

Test Plan:
- Reset: hold CLR=0 for 2 cycles with random inputs -> all outputs 0; release with no start -> outputs remain 0.
- Basic frame (defaults):
  - Stimulus: start with bit_en every cycle, d_in bits LSB-first 1,0,1,1,0,0,1,0; b_in=1 on bit 3 only.
  - Response: 1 cycle after bit 7, out_valid=1, word_out=8'h4D, borrow_out=2'b01.
  - out_ready=1 -> out_valid=0 the next cycle.
- Gapped input:
  - Stimulus: same frame with bit_en=0 inserted after bits 2 and 5 (3 idle cycles each); b_in=1 on bit 7 only.
  - Response: word_out=8'h4D, borrow_out=2'b10; b_in=1 held during gap cycles has no effect.
- Back-to-back with stall:
  - Stimulus: send word 8'hA5, then immediately word 8'h3C with out_ready=0 throughout.
  - Response: buffer holds 8'hA5, 8'h3C is dropped, overrun=1.
  - Rerun with out_ready=1 on the completion cycle of 8'h3C -> buffer reloads to 8'h3C, out_valid stays 1, overrun stays 0.
- Abort: start re-asserted at bit 4 of a frame, then 8 bits encoding 8'hF0 -> only 8'hF0 is output; no output for the aborted frame.
- Reset mid-frame:
  - Stimulus: CLR=0 at bit 5 of a frame.
  - Response: busy=0, out_valid=0, overrun=0; the next full frame 8'h81 is received correctly.

Source files
------------

// File: rtl/serial_diff_collector.sv
// Deserialises the LSB-first D/B stream of the serial subtractor FSM into a
// parallel word plus per-group borrow vector, held in a one-entry output buffer.
module serial_diff_collector #(
  parameter int GROUP_BITS = 4,
  parameter int NUM_GROUPS = 2
) (
  input  logic                             CLK,
  input  logic                             CLR,
  input  logic                             start,
  input  logic                             bit_en,
  input  logic                             d_in,
  input  logic                             b_in,
  output logic [GROUP_BITS*NUM_GROUPS-1:0] word_out,
  output logic [NUM_GROUPS-1:0]            borrow_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             overrun
);

  localparam int W  = GROUP_BITS * NUM_GROUPS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         idx;
  logic [W-1:0]          shift_q;
  logic [W-1:0]          shift_d;
  logic [NUM_GROUPS-1:0] borrow_q;
  logic [NUM_GROUPS-1:0] borrow_d;
  logic                  accept;
  logic                  complete;

  // A start bit always lands at index 0, discarding any partial frame.
  always_comb begin
    accept   = bit_en && (start || state == COLLECT);
    idx      = (start || state == IDLE) ? '0 : cnt;
    shift_d  = (idx == '0) ? '0 : shift_q;
    borrow_d = (idx == '0) ? '0 : borrow_q;
    for (int i = 0; i < W; i++)
      if (idx == CW'(i)) shift_d[i] = d_in;
    for (int g = 0; g < NUM_GROUPS; g++)
      if (idx == CW'(g * GROUP_BITS + GROUP_BITS - 1)) borrow_d[g] = b_in;
    complete = accept && (idx == CW'(W - 1));
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_q    <= '0;
      borrow_q   <= '0;
      word_out   <= '0;
      borrow_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        shift_q  <= shift_d;
        borrow_q <= borrow_d;
        if (complete) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= COLLECT;
          cnt   <= idx + 1'b1;
        end
      end
      // A finished word loads if the buffer is empty or draining this cycle.
      if (complete && (!out_valid || out_ready)) begin
        word_out   <= shift_d;
        borrow_out <= borrow_d;
        out_valid  <= 1'b1;
      end else begin
        if (complete) overrun <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == COLLECT);

endmodule
